// File: rtl/zre_pkg.sv
// Shared constants for the zero-run expander: token kinds, FSM encoding and
// the default byte width.
package zre_pkg;

  localparam int unsigned ZRE_WIDTH = 8;

  // Token kind carried on in_is_run
  localparam logic TOK_LIT = 1'b0;
  localparam logic TOK_RUN = 1'b1;

  // Expander state encoding
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/zero_run_expander_if.sv
// Token-in / byte-out handshake bundle for the zero-run expander.
//   in_valid/in_ready/in_is_run/in_data : token channel (expander is sink)
//   out_valid/out_ready/out_data/out_zero : byte channel (expander is source)
//   busy : expander is emitting a multi-byte run
// slave  = expander view, master = environment (token source + byte sink).
interface zero_run_expander_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_is_run;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             busy;

  modport slave (
    input  in_valid, in_is_run, in_data, out_ready,
    output in_ready, out_valid, out_data, out_zero, busy
  );

  modport master (
    output in_valid, in_is_run, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_zero, busy
  );
endinterface

// File: rtl/byte_zero_detect.sv
// All-zero detector: zero_o is the NOR of every bit of data_i.
//   data_i : byte under test
//   zero_o : high iff data_i == 0
module byte_zero_detect
  import zre_pkg::*;
#(
  parameter int unsigned WIDTH = ZRE_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             zero_o
);
  assign zero_o = ~|data_i;
endmodule

// File: rtl/zero_run_expander.sv
// Expands a token stream (literal bytes and zero-run counts) into one byte per
// beat. A single output register holds the current byte; a run token loads
// its first zero immediately and the RUN state supplies the remaining zeros.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : token in / byte out handshakes, out_zero flag, busy
module zero_run_expander
  import zre_pkg::*;
#(
  parameter int unsigned WIDTH = ZRE_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  zero_run_expander_if.slave  bus
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic             state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             slot_free;
  logic             fire;

  // Slot can take a new byte if empty or being drained this cycle
  assign slot_free    = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = (state_q == ST_IDLE) & slot_free;
  assign fire         = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (state_q == ST_IDLE) begin
      if (fire) begin
        out_valid_d = 1'b1;
        if (bus.in_is_run == TOK_LIT) begin
          out_data_d = bus.in_data;
        end else begin
          out_data_d  = '0;
          // Length 0 means 2^WIDTH, so N-1 is in_data-1 with natural wrap
          remaining_d = bus.in_data - One;
          state_d     = (bus.in_data == One) ? ST_IDLE : ST_RUN;
        end
      end else if (slot_free) begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (slot_free) begin
        out_valid_d = 1'b1;
        out_data_d  = '0;
        remaining_d = remaining_q - One;
        if (remaining_q == One) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q == ST_RUN);

  byte_zero_detect #(
    .WIDTH (WIDTH)
  ) u_zero_detect (
    .data_i (out_data_q),
    .zero_o (bus.out_zero)
  );

endmodule

// File: tb/tb_zero_run_expander.sv
// Bench for zero_run_expander: directed vectors with literal expectations plus
// a queue model of the expanded byte stream checked on every output transfer.
module tb_zero_run_expander;
  import zre_pkg::*;

  localparam int unsigned W = ZRE_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zero_run_expander_if #(.WIDTH(W)) bus ();

  zero_run_expander #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int last_wait = 0;
  bit rand_rdy = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a token until accepted; on acceptance append its expansion to the model.
  task automatic send(input logic is_run, input logic [W-1:0] d);
    int n = 0;
    int len;
    bus.in_valid  = 1'b1;
    bus.in_is_run = is_run;
    bus.in_data   = d;
    @(negedge clk);
    while (!bus.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready still 0 after %0d cycles, expected 1", n);
    end else if (is_run == TOK_LIT) begin
      exp_q.push_back(d);
    end else begin
      len = (d == '0) ? (1 << W) : int'(d);
      for (int i = 0; i < len; i++) exp_q.push_back('0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard: every transfer must match the model, flag must match data.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      chk("zero_flag", 32'(bus.out_zero), 32'(bus.out_data == '0));
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_beat: got byte %0h, expected no output", bus.out_data);
        end else begin
          chk("stream", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    logic          r;
    logic [W-1:0]  d;
    bus.in_valid  = 1'b0;
    bus.in_is_run = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_zero", 32'(bus.out_zero), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back literals, 1-cycle latency
    send(TOK_LIT, 8'h41);
    chk("lit41_wait", 32'(last_wait), 32'd0);
    chk("lit41_valid", 32'(bus.out_valid), 32'd1);
    chk("lit41_data", 32'(bus.out_data), 32'h41);
    chk("lit41_zero", 32'(bus.out_zero), 32'd0);
    send(TOK_LIT, 8'h00);
    chk("lit00_wait", 32'(last_wait), 32'd0);
    chk("lit00_data", 32'(bus.out_data), 32'h00);
    chk("lit00_zero", 32'(bus.out_zero), 32'd1);
    send(TOK_LIT, 8'hFF);
    chk("litff_wait", 32'(last_wait), 32'd0);
    chk("litff_data", 32'(bus.out_data), 32'hFF);
    chk("litff_zero", 32'(bus.out_zero), 32'd0);

    // Run of 3: busy and in_ready gap for 2 cycles
    send(TOK_RUN, 8'd3);
    chk("run3_b1_valid", 32'(bus.out_valid), 32'd1);
    chk("run3_b1_data", 32'(bus.out_data), 32'd0);
    chk("run3_b1_zero", 32'(bus.out_zero), 32'd1);
    chk("run3_b1_busy", 32'(bus.busy), 32'd1);
    chk("run3_b1_rdy", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("run3_b2_valid", 32'(bus.out_valid), 32'd1);
    chk("run3_b2_busy", 32'(bus.busy), 32'd1);
    chk("run3_b2_rdy", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("run3_b3_valid", 32'(bus.out_valid), 32'd1);
    chk("run3_b3_busy", 32'(bus.busy), 32'd0);
    chk("run3_b3_rdy", 32'(bus.in_ready), 32'd1);
    send(TOK_LIT, 8'h12);
    chk("lit12_wait", 32'(last_wait), 32'd0);
    chk("lit12_data", 32'(bus.out_data), 32'h12);

    // Length 0 encodes 256
    send(TOK_RUN, 8'h00);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.out_valid) break;
      cnt++;
    end
    chk("run256_count", 32'(cnt), 32'd256);
    chk("run256_busy", 32'(bus.busy), 32'd0);
    chk("run256_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Backpressure holds the slot
    bus.out_ready = 1'b0;
    send(TOK_LIT, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_data", 32'(bus.out_data), 32'h5A);
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Reset mid-run discards the rest of the run
    send(TOK_RUN, 8'd10);
    repeat (3) @(posedge clk);
    #1;
    chk("mr_b4_busy", 32'(bus.busy), 32'd1);
    chk("mr_b4_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mr_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_rst_zero", 32'(bus.out_zero), 32'd1);
    chk("mr_rst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mr_post_idle", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(TOK_LIT, 8'h33);
    chk("mr_lit33_valid", 32'(bus.out_valid), 32'd1);
    chk("mr_lit33_data", 32'(bus.out_data), 32'h33);

    // Random token stream against the queue model
    rand_rdy = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      r = ($urandom_range(0, 2) == 0);
      if (r) begin
        d = ($urandom_range(0, 49) == 0) ? '0 : W'($urandom_range(1, 8));
      end else begin
        d = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(0, 255));
      end
      send(r, d);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
